buzzer_sequencer: RTL and testbench
===================================

// Module: buzzer_sequencer
// PURPOSE
// Sequences and arbitrates the buzzer tone datapath for the taximeter. Drives the
// tone generator's enable and 4-bit note index from three sources: key-click
// beep, 16-step melody, and a two-tone alarm. Sits between the control FSM/keypad
// logic and the tone generator. Owns all timing of note durations and gaps.
// PARAMETERS
// CNT_W         24          width of the duration down-counter
// NOTE_CYCLES   12_500_000  melody note-on length in clk cycles (0.25 s @ 50 MHz), >=1
// GAP_CYCLES    1_250_000   melody silence after each note, >=1
// KEY_CYCLES    2_500_000   key-click beep length, >=1
// ALARM_CYCLES  6_250_000   length of each alarm half-tone, >=1
// KEY_NOTE      4'd3        note index used for key click
// ALARM_NOTE_A  4'd3        alarm first tone;  ALARM_NOTE_B 4'd8 second tone
// PORTS
// clk          in   1  system clock, rising edge
// rst          in   1  asynchronous, active-low reset
// req_key      in   1  single-cycle pulse: request key-click beep
// req_melody   in   1  single-cycle pulse: request melody playback
// alarm_on     in   1  level: alarm active while high
// buz_enable   out  1  tone generator enable
// buz_data     out  4  tone generator note index
// busy         out  1  high whenever state != IDLE
// melody_done  out  1  single-cycle pulse when a melody completes normally
// src          out  2  current source: 00 idle, 01 key, 10 melody, 11 alarm
// BEHAVIOUR
// - rst=0: immediately (async) state=IDLE, all outputs 0, counters 0, pending flags 0.
// - All outputs registered. req_key/req_melody latched into pend_key/pend_melody.
// - States: IDLE, KEY, MEL_ON, MEL_GAP, ALARM. Arbitration uses (req | pend).
// - IDLE priority: alarm_on > melody > key. Request sampled at edge k -> new state,
//   buz_enable=1, buz_data, src valid after edge k (1-cycle latency).
// - Each timed state lasts exactly its *_CYCLES: counter loads N-1, counts to 0.
// - KEY: buz_enable=1, buz_data=KEY_NOTE, KEY_CYCLES -> IDLE. No gap.
// - MEL_ON step s (0..15): buz_enable=1, buz_data=s, NOTE_CYCLES -> MEL_GAP.
// - MEL_GAP: buz_enable=0, buz_data holds s, GAP_CYCLES -> MEL_ON s+1; after s=15
//   -> IDLE with melody_done=1 for that one cycle. Total 16*(NOTE+GAP) cycles.
// - ALARM: buz_enable=1, buz_data alternates A,B each ALARM_CYCLES, starting A.
//   alarm_on low at edge k -> IDLE after edge k (abort mid-tone).
// - alarm_on rising in KEY/MEL_*: preempt at next edge; melody/key aborted, no
//   melody_done, not resumed; step counter reset to 0.
// - req_key while not IDLE: discarded (pend_key cleared). Simultaneous key+melody
//   in IDLE: melody plays, key discarded.
// - req_melody during ALARM or melody: stays pending; plays after return to IDLE.
// - Pending flag cleared on the edge its source is granted.
// STRUCTURE
// - Shared header buzzer_defs.vh: state encodings, src codes, default note indices.
// - One sub-module: step_timer (loadable CNT_W down-counter, load/en in, zero flag).
// - Arbitration, step counter and output registers stay in this module.
// TESTING  (NOTE=4, GAP=2, KEY=3, ALARM=5)
// 1 req_key pulse -> src=01, buz_data=3, buz_enable=1 for 3 cycles, then all 0.
// 2 req_melody -> buz_data 0..15, each on 4/off 2; melody_done at cycle 96; busy low after.
// 3 alarm_on high at melody step 5 -> next cycle src=11, data 3,8,3.. every 5 cycles;
//   drop alarm_on -> IDLE next edge, no melody_done.
// 4 req_key during melody -> ignored; req_melody during alarm -> melody starts after alarm.
// 5 req_key+req_melody same cycle in IDLE -> melody only, no key beep afterward.
// 6 rst low mid-MEL_ON (no clock edge) -> outputs 0 at once; release -> IDLE, idle outputs.

Source files
------------

// File: rtl/buzzer_sequencer_pkg.sv
// Shared definitions for the taximeter buzzer sequencer: state encodings,
// source codes and default note indices.
package buzzer_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_KEY     = 3'd1,
        ST_MEL_ON  = 3'd2,
        ST_MEL_GAP = 3'd3,
        ST_ALARM   = 3'd4
    } state_e;

    localparam logic [1:0] SRC_IDLE  = 2'b00;
    localparam logic [1:0] SRC_KEY   = 2'b01;
    localparam logic [1:0] SRC_MEL   = 2'b10;
    localparam logic [1:0] SRC_ALARM = 2'b11;

    localparam logic [3:0] KEY_NOTE_DEF     = 4'd3;
    localparam logic [3:0] ALARM_NOTE_A_DEF = 4'd3;
    localparam logic [3:0] ALARM_NOTE_B_DEF = 4'd8;
    localparam logic [3:0] LAST_STEP        = 4'd15;

    // Source code reported on the src output for a given state.
    function automatic logic [1:0] src_of(input state_e s);
        logic [1:0] code;
        case (s)
            ST_KEY:     code = SRC_KEY;
            ST_MEL_ON:  code = SRC_MEL;
            ST_MEL_GAP: code = SRC_MEL;
            ST_ALARM:   code = SRC_ALARM;
            default:    code = SRC_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/buzzer_sequencer_step_timer.sv
// Loadable down-counter used to time note, gap, key-click and alarm phases.
// A load of N-1 followed by counting to zero gives a phase of exactly N cycles.
module step_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // Counter register: load has priority, otherwise count down and stick at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/buzzer_sequencer.sv
// Buzzer sequencer: arbitrates key-click, 16-step melody and two-tone alarm
// sources onto the tone generator enable / note index, with registered outputs.
module buzzer_sequencer
    import buzzer_sequencer_pkg::*;
#(
    parameter int         CNT_W        = 24,
    parameter int         NOTE_CYCLES  = 12_500_000,
    parameter int         GAP_CYCLES   = 1_250_000,
    parameter int         KEY_CYCLES   = 2_500_000,
    parameter int         ALARM_CYCLES = 6_250_000,
    parameter logic [3:0] KEY_NOTE     = KEY_NOTE_DEF,
    parameter logic [3:0] ALARM_NOTE_A = ALARM_NOTE_A_DEF,
    parameter logic [3:0] ALARM_NOTE_B = ALARM_NOTE_B_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_key,
    input  logic       req_melody,
    input  logic       alarm_on,
    output logic       buz_enable,
    output logic [3:0] buz_data,
    output logic       busy,
    output logic       melody_done,
    output logic [1:0] src
);

    localparam logic [CNT_W-1:0] NOTE_LD  = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] KEY_LD   = CNT_W'(KEY_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALARM_LD = CNT_W'(ALARM_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       step_q, step_d;
    logic             half_q, half_d;
    logic             pend_key_q, pend_key_d;
    logic             pend_melody_q, pend_melody_d;
    logic             done_d;
    logic             buz_enable_d, busy_d;
    logic [3:0]       buz_data_d;
    logic [1:0]       src_d;
    logic             tmr_load_s, tmr_zero_s;
    logic [CNT_W-1:0] tmr_val_s;
    logic             key_act_s, mel_act_s;

    assign key_act_s = req_key | pend_key_q;
    assign mel_act_s = req_melody | pend_melody_q;

    step_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (tmr_load_s),
        .en_i       (1'b1),
        .load_val_i (tmr_val_s),
        .zero_o     (tmr_zero_s)
    );

    // Next-state logic: arbitration in IDLE, phase sequencing, alarm preemption.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        half_d        = half_q;
        pend_key_d    = 1'b0;   // a key click never waits: granted or discarded
        pend_melody_d = pend_melody_q | req_melody;
        done_d        = 1'b0;
        tmr_load_s    = 1'b0;
        tmr_val_s     = {CNT_W{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (alarm_on) begin
                    state_d    = ST_ALARM;
                    half_d     = 1'b0;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = ALARM_LD;
                end else if (mel_act_s) begin
                    state_d       = ST_MEL_ON;
                    step_d        = 4'd0;
                    pend_melody_d = 1'b0;
                    tmr_load_s    = 1'b1;
                    tmr_val_s     = NOTE_LD;
                end else if (key_act_s) begin
                    state_d    = ST_KEY;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = KEY_LD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KEY, ST_MEL_ON, ST_MEL_GAP: begin
                if (alarm_on) begin
                    // Preempted source is abandoned, melody restarts from step 0 later.
                    state_d    = ST_ALARM;
                    step_d     = 4'd0;
                    half_d     = 1'b0;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = ALARM_LD;
                end else if (!tmr_zero_s) begin
                    state_d = state_q;
                end else if (state_q == ST_KEY) begin
                    state_d = ST_IDLE;
                end else if (state_q == ST_MEL_ON) begin
                    state_d    = ST_MEL_GAP;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = GAP_LD;
                end else if (step_q == LAST_STEP) begin
                    state_d = ST_IDLE;
                    step_d  = 4'd0;
                    done_d  = 1'b1;
                end else begin
                    state_d    = ST_MEL_ON;
                    step_d     = step_q + 4'd1;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = NOTE_LD;
                end
            end
            ST_ALARM: begin
                if (!alarm_on) begin
                    state_d = ST_IDLE;
                end else if (tmr_zero_s) begin
                    half_d     = ~half_q;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = ALARM_LD;
                end else begin
                    state_d = ST_ALARM;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = 4'd0;
                half_d  = 1'b0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs track the state.
    always_comb begin
        buz_enable_d = 1'b0;
        buz_data_d   = 4'd0;
        case (state_d)
            ST_KEY: begin
                buz_enable_d = 1'b1;
                buz_data_d   = KEY_NOTE;
            end
            ST_MEL_ON: begin
                buz_enable_d = 1'b1;
                buz_data_d   = step_d;
            end
            ST_MEL_GAP: begin
                buz_enable_d = 1'b0;
                buz_data_d   = step_d;
            end
            ST_ALARM: begin
                buz_enable_d = 1'b1;
                buz_data_d   = half_d ? ALARM_NOTE_B : ALARM_NOTE_A;
            end
            default: begin
                buz_enable_d = 1'b0;
                buz_data_d   = 4'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        src_d  = src_of(state_d);
    end

    // State, pending flags and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            step_q        <= 4'd0;
            half_q        <= 1'b0;
            pend_key_q    <= 1'b0;
            pend_melody_q <= 1'b0;
            buz_enable    <= 1'b0;
            buz_data      <= 4'd0;
            busy          <= 1'b0;
            melody_done   <= 1'b0;
            src           <= 2'b00;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            half_q        <= half_d;
            pend_key_q    <= pend_key_d;
            pend_melody_q <= pend_melody_d;
            buz_enable    <= buz_enable_d;
            buz_data      <= buz_data_d;
            busy          <= busy_d;
            melody_done   <= done_d;
            src           <= src_d;
        end
    end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Self-checking bench for buzzer_sequencer with short phase lengths.
module tb_buzzer_sequencer;

    localparam int NOTE    = 4;
    localparam int GAP     = 2;
    localparam int KEYC    = 3;
    localparam int ALRM    = 5;
    localparam int PERIOD  = NOTE + GAP;
    localparam int MEL_LEN = 16 * PERIOD;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       req_key    = 1'b0;
    logic       req_melody = 1'b0;
    logic       alarm_on   = 1'b0;
    logic       buz_enable;
    logic [3:0] buz_data;
    logic       busy;
    logic       melody_done;
    logic [1:0] src;

    int total = 0;
    int bad   = 0;
    int cycles;

    always #5 clk = ~clk;

    buzzer_sequencer #(
        .CNT_W        (24),
        .NOTE_CYCLES  (NOTE),
        .GAP_CYCLES   (GAP),
        .KEY_CYCLES   (KEYC),
        .ALARM_CYCLES (ALRM),
        .KEY_NOTE     (4'd3),
        .ALARM_NOTE_A (4'd3),
        .ALARM_NOTE_B (4'd8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_key     (req_key),
        .req_melody  (req_melody),
        .alarm_on    (alarm_on),
        .buz_enable  (buz_enable),
        .buz_data    (buz_data),
        .busy        (busy),
        .melody_done (melody_done),
        .src         (src)
    );

    // Model: which source is active (0 idle,1 key,2 melody,3 alarm) and cycles since it began.
    int m_mode;
    int m_t;
    bit m_pend;
    bit m_done;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode <= 0; m_t <= 0; m_pend <= 1'b0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_mode == 0) begin
                if (alarm_on) begin
                    m_mode <= 3; m_t <= 0; m_pend <= m_pend | req_melody;
                end else if (req_melody || m_pend) begin
                    m_mode <= 2; m_t <= 0; m_pend <= 1'b0;
                end else if (req_key) begin
                    m_mode <= 1; m_t <= 0;
                end
            end else begin
                m_pend <= m_pend | req_melody;
                if (m_mode == 3) begin
                    if (!alarm_on) begin m_mode <= 0; m_t <= 0; end
                    else m_t <= m_t + 1;
                end else if (alarm_on) begin
                    m_mode <= 3; m_t <= 0;
                end else if (m_mode == 1 && m_t + 1 == KEYC) begin
                    m_mode <= 0; m_t <= 0;
                end else if (m_mode == 2 && m_t + 1 == MEL_LEN) begin
                    m_mode <= 0; m_t <= 0; m_done <= 1'b1;
                end else begin
                    m_t <= m_t + 1;
                end
            end
        end
    end

    // Expected packed outputs {enable, data, busy, done, src} from the model.
    function automatic logic [8:0] expect_out(input int mode, input int t, input bit done);
        logic [3:0] d;
        bit on;
        case (mode)
            1: return {1'b1, 4'd3, 1'b1, 1'b0, 2'b01};
            2: begin
                d  = 4'(t / PERIOD);
                on = (t % PERIOD) < NOTE;
                return {on, d, 1'b1, 1'b0, 2'b10};
            end
            3: begin
                d = (((t / ALRM) % 2) == 1) ? 4'd8 : 4'd3;
                return {1'b1, d, 1'b1, 1'b0, 2'b11};
            end
            default: return {1'b0, 4'd0, 1'b0, done, 2'b00};
        endcase
    endfunction

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        logic [8:0] exp_v;
        logic [8:0] act_v;
        exp_v = expect_out(m_mode, m_t, m_done);
        act_v = {buz_enable, buz_data, busy, melody_done, src};
        total = total + 1;
        if (act_v !== exp_v) begin
            bad = bad + 1;
            $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act_v, exp_v);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input bit k, input bit m);
        req_key    = k;
        req_melody = m;
        tick();
        req_key    = 1'b0;
        req_melody = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (!melody_done && n < bound) begin
            tick();
            n = n + 1;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("reset_outputs", {buz_enable, buz_data, busy, melody_done, src}, 8'h00);
        rst = 1'b1;
        repeat (2) tick();

        // 1: key click, 3 cycles of note 3
        pulse(1'b1, 1'b0);
        check("key_src", {6'd0, src}, 8'd1);
        check("key_data", {4'd0, buz_data}, 8'd3);
        check("key_en", {7'd0, buz_enable}, 8'd1);
        repeat (2) tick();
        check("key_last_cycle", {7'd0, buz_enable}, 8'd1);
        tick();
        check("key_end", {buz_enable, buz_data, busy, src}, 8'h00);

        // 2: full melody, done pulse 96 cycles after grant
        pulse(1'b0, 1'b1);
        check("mel_step0", {3'd0, buz_enable, buz_data}, 8'h10);
        wait_done(200, cycles);
        check("mel_done_cycle", 8'(cycles), 8'd96);
        tick();
        check("mel_idle_after", {busy, melody_done}, 8'd0);

        // 3: alarm preempts melody at step 5, then is dropped
        pulse(1'b0, 1'b1);
        cycles = 0;
        while (buz_data != 4'd5 && cycles < 100) begin
            tick();
            cycles = cycles + 1;
        end
        check("reach_step5", {4'd0, buz_data}, 8'd5);
        alarm_on = 1'b1;
        tick();
        check("alarm_src", {6'd0, src}, 8'd3);
        check("alarm_tone_a", {4'd0, buz_data}, 8'd3);
        repeat (5) tick();
        check("alarm_tone_b", {4'd0, buz_data}, 8'd8);
        repeat (7) tick();
        alarm_on = 1'b0;
        tick();
        check("alarm_drop_idle", {busy, src}, 8'd0);
        repeat (4) tick();

        // 4: key ignored during melody; melody requested during alarm plays afterwards
        pulse(1'b0, 1'b1);
        repeat (10) tick();
        pulse(1'b1, 1'b0);
        tick();
        check("key_ignored", {6'd0, src}, 8'd2);
        alarm_on = 1'b1;
        repeat (3) tick();
        pulse(1'b0, 1'b1);
        repeat (4) tick();
        alarm_on = 1'b0;
        tick();
        check("alarm_end_idle", {6'd0, src}, 8'd0);
        tick();
        check("pending_mel_src", {6'd0, src}, 8'd2);
        check("pending_mel_data", {4'd0, buz_data}, 8'd0);
        wait_done(120, cycles);
        check("pending_mel_done", {7'd0, melody_done}, 8'd1);
        tick();

        // 5: key and melody together -> melody only
        pulse(1'b1, 1'b1);
        check("both_src", {6'd0, src}, 8'd2);
        wait_done(120, cycles);
        check("both_done", {7'd0, melody_done}, 8'd1);
        repeat (6) tick();
        check("no_key_after", {busy, src}, 8'd0);

        // 6: asynchronous reset in MEL_ON
        pulse(1'b0, 1'b1);
        repeat (2) tick();
        check("pre_reset_on", {7'd0, buz_enable}, 8'd1);
        rst = 1'b0;
        #1;
        check("async_reset", {buz_enable, buz_data, busy, melody_done, src}, 8'h00);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("after_release", {buz_enable, buz_data, busy, melody_done, src}, 8'h00);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
